// File: rtl/rob_if.sv
// Reorder-buffer port bundle.
//   slave  : the ROB side. It receives allocs, writebacks and lookup tags. It drives
//            alloc handshake, lookup results, commit and redirect information, and occupancy.
//   master : the decode / execute / regfile side. It is the mirror image of slave.
// Multi-channel writeback fields are flat packed vectors. Channel c occupies slice [c*W +: W].
interface rob_if #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  parameter int NWB   = 2
);
  // Allocation from decode
  logic              alloc_valid;
  logic              alloc_ready;
  logic [1:0]        alloc_kind;   // 0=REG 1=STORE 2=BRANCH 3=JALR
  logic [4:0]        alloc_rd;
  logic              alloc_pred;
  logic [XLEN-1:0]   alloc_alt;
  logic [TAG_W-1:0]  alloc_tag;
  // Result channels
  logic [NWB-1:0]       wb_valid;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*XLEN-1:0]  wb_val;
  logic [NWB*XLEN-1:0]  wb_tgt;
  // Operand lookups
  logic [TAG_W-1:0]  q1_tag, q2_tag;
  logic              q1_ready, q2_ready;
  logic [XLEN-1:0]   q1_val, q2_val;
  // Commit / redirect
  logic              cm_valid;
  logic [TAG_W-1:0]  cm_tag;
  logic              cm_we;
  logic [4:0]        cm_rd;
  logic [XLEN-1:0]   cm_val;
  logic              cm_store;
  logic              flush;
  logic [XLEN-1:0]   flush_pc;
  logic [TAG_W:0]    count;

  modport slave (
    input  alloc_valid, alloc_kind, alloc_rd, alloc_pred, alloc_alt,
    input  wb_valid, wb_tag, wb_val, wb_tgt, q1_tag, q2_tag,
    output alloc_ready, alloc_tag, q1_ready, q1_val, q2_ready, q2_val,
    output cm_valid, cm_tag, cm_we, cm_rd, cm_val, cm_store, flush, flush_pc, count
  );

  modport master (
    output alloc_valid, alloc_kind, alloc_rd, alloc_pred, alloc_alt,
    output wb_valid, wb_tag, wb_val, wb_tgt, q1_tag, q2_tag,
    input  alloc_ready, alloc_tag, q1_ready, q1_val, q2_ready, q2_val,
    input  cm_valid, cm_tag, cm_we, cm_rd, cm_val, cm_store, flush, flush_pc, count
  );
endinterface

// File: rtl/rob_multiport.sv
// rob_multiport: in-order-commit reorder buffer with NWB writeback channels.
//   clk, rst : clock and synchronous active-high reset
//   rdy      : global enable. When low, all state holds and the commit/store/flush pulses are masked.
//   bus      : rob_if.slave. It carries alloc (one per cycle), NWB writebacks, and two bypassing
//              operand lookups. It also carries the registered commit/flush pulses and count.
// The head and tail pointers carry one extra wrap bit. With that bit, tail-head gives DEPTH when the buffer is full.
module rob_multiport #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  parameter int NWB   = 2
) (
  input logic   clk,
  input logic   rst,
  input logic   rdy,
  rob_if.slave  bus
);
  typedef enum logic [1:0] {K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_JALR = 2'd3} kind_e;

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W + 1)'(1);

  // Control state (reset)
  logic [TAG_W:0]   head_q, tail_q;
  logic [DEPTH-1:0] busy_q, ready_q;
  logic             cm_valid_q, cm_we_q, cm_store_q, flush_q;
  logic [TAG_W-1:0] cm_tag_q;
  logic [4:0]       cm_rd_q;
  logic [XLEN-1:0]  cm_val_q, flush_pc_q;

  // Entry payload (not reset)
  kind_e            kind_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [DEPTH-1:0] pred_q;
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [XLEN-1:0]  pc_q   [DEPTH];   // BRANCH: fall-back PC; JALR: jump target from writeback

  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             alloc_ok, do_alloc, do_commit, mispredict;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign alloc_ok = !bus.count[TAG_W] && !flush_q;
  assign do_alloc = bus.alloc_valid && alloc_ok;
  // A writeback that lands on the head this cycle has not yet updated ready_q,
  // so it commits on the following cycle.
  assign do_commit  = busy_q[head_idx] && ready_q[head_idx] && !flush_q;
  assign mispredict = val_q[head_idx][0] != pred_q[head_idx];

  // Writeback channel unpacking. Hits only count on busy entries.
  logic [TAG_W-1:0] wb_tag_a [NWB];
  logic [XLEN-1:0]  wb_val_a [NWB];
  logic [XLEN-1:0]  wb_tgt_a [NWB];
  logic [NWB-1:0]   wb_hit;

  for (genvar c = 0; c < NWB; c++) begin : g_wb
    assign wb_tag_a[c] = bus.wb_tag[c*TAG_W +: TAG_W];
    assign wb_val_a[c] = bus.wb_val[c*XLEN +: XLEN];
    assign wb_tgt_a[c] = bus.wb_tgt[c*XLEN +: XLEN];
    assign wb_hit[c]   = bus.wb_valid[c] && busy_q[wb_tag_a[c]];
  end

  // Operand lookups with same-cycle bypass.
  // Channels are scanned high to low, so the lowest channel index has the final say.
  logic [TAG_W-1:0] q_tag [2];
  logic             q_rdy [2];
  logic [XLEN-1:0]  q_val [2];

  assign q_tag[0] = bus.q1_tag;
  assign q_tag[1] = bus.q2_tag;

  // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      q_rdy[q] = ready_q[q_tag[q]];
      q_val[q] = val_q[q_tag[q]];
      for (int c = NWB - 1; c >= 0; c--) begin
        if (wb_hit[c] && wb_tag_a[c] == q_tag[q]) begin
          q_rdy[q] = 1'b1;
          q_val[q] = wb_val_a[c];
        end
      end
      q_rdy[q] = q_rdy[q] && busy_q[q_tag[q]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so that every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      cm_valid_q <= 1'b0;
      cm_we_q    <= 1'b0;
      cm_store_q <= 1'b0;
      flush_q    <= 1'b0;
      cm_tag_q   <= '0;
      cm_rd_q    <= '0;
      cm_val_q   <= '0;
      flush_pc_q <= '0;
    end else if (rdy) begin
      cm_valid_q <= 1'b0;
      cm_we_q    <= 1'b0;
      cm_store_q <= 1'b0;
      flush_q    <= 1'b0;
      if (flush_q) begin
        // Redirect in progress: drop every in-flight entry and ignore this cycle's traffic.
        head_q  <= '0;
        tail_q  <= '0;
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (do_commit) begin
          busy_q[head_idx] <= 1'b0;
          head_q           <= head_q + PTR_ONE;
          cm_valid_q       <= 1'b1;
          cm_tag_q         <= head_idx;
          cm_rd_q          <= rd_q[head_idx];
          cm_val_q         <= val_q[head_idx];
          cm_we_q          <= (kind_q[head_idx] == K_REG || kind_q[head_idx] == K_JALR)
                              && rd_q[head_idx] != 5'd0;
          cm_store_q       <= kind_q[head_idx] == K_STORE;
          flush_q          <= kind_q[head_idx] == K_JALR
                              || (kind_q[head_idx] == K_BRANCH && mispredict);
          flush_pc_q       <= pc_q[head_idx];
        end
        if (do_alloc) begin
          busy_q[tail_idx]  <= 1'b1;
          ready_q[tail_idx] <= bus.alloc_kind == K_STORE;
          tail_q            <= tail_q + PTR_ONE;
        end
        for (int c = NWB - 1; c >= 0; c--) begin
          if (wb_hit[c]) ready_q[wb_tag_a[c]] <= 1'b1;
        end
      end
    end
  end

  // NOTE: the payload array is deliberately left out of reset. busy_q gates every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !flush_q) begin
      if (do_alloc) begin
        kind_q[tail_idx] <= kind_e'(bus.alloc_kind);
        rd_q[tail_idx]   <= bus.alloc_rd;
        pred_q[tail_idx] <= bus.alloc_pred;
        pc_q[tail_idx]   <= bus.alloc_alt;
      end
      for (int c = NWB - 1; c >= 0; c--) begin
        if (wb_hit[c]) begin
          val_q[wb_tag_a[c]] <= wb_val_a[c];
          if (kind_q[wb_tag_a[c]] == K_JALR) pc_q[wb_tag_a[c]] <= wb_tgt_a[c];
        end
      end
    end
  end

  assign bus.alloc_ready = alloc_ok;
  assign bus.alloc_tag   = tail_idx;
  assign bus.q1_ready    = q_rdy[0];
  assign bus.q1_val      = q_val[0];
  assign bus.q2_ready    = q_rdy[1];
  assign bus.q2_val      = q_val[1];
  // The pulses hold their value while rdy is low and reappear once rdy returns,
  // so a pulse is never lost.
  assign bus.cm_valid    = cm_valid_q && rdy;
  assign bus.cm_store    = cm_store_q && rdy;
  assign bus.flush       = flush_q && rdy;
  assign bus.cm_tag      = cm_tag_q;
  assign bus.cm_we       = cm_we_q;
  assign bus.cm_rd       = cm_rd_q;
  assign bus.cm_val      = cm_val_q;
  assign bus.flush_pc    = flush_pc_q;
  assign bus.count       = tail_q - head_q;
endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: a per-cycle vector table plus directed multi-cycle sequences.
// Inputs are driven 2 time units after the rising edge, and outputs are sampled 1 unit later.
module tb_rob_multiport;
  localparam int DEPTH = 16, TAG_W = 4, XLEN = 32, NWB = 2;
  localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_JALR = 2'd3;
  localparam int NV = 19;

  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;

  rob_if #(.TAG_W(TAG_W), .XLEN(XLEN), .NWB(NWB)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .NWB(NWB)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct {
    logic av; logic [1:0] ak; logic [4:0] ard;
    logic w0v; logic [3:0] w0t; logic [31:0] w0d;
    logic w1v; logic [3:0] w1t; logic [31:0] w1d;
    logic [3:0] qt;
    logic [4:0] e_cnt; logic e_ardy; logic [3:0] e_atag;
    logic e_qr; logic [31:0] e_qv;
    logic e_cm; logic [3:0] e_ctag; logic e_we; logic [4:0] e_rd; logic [31:0] e_cval;
  } vec_t;

  vec_t vecs [NV];
  int n_pass = 0, n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0; bus.alloc_kind = K_REG; bus.alloc_rd = '0;
    bus.alloc_pred = 1'b0;  bus.alloc_alt = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_val = '0; bus.wb_tgt = '0;
    bus.q1_tag = '0; bus.q2_tag = '0;
  endtask

  task automatic alloc(input logic [1:0] k, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
    bus.alloc_valid = 1'b1; bus.alloc_kind = k; bus.alloc_rd = rd;
    bus.alloc_pred = pred;  bus.alloc_alt = alt;
  endtask

  task automatic wb(input int ch, input logic [3:0] tag, input logic [31:0] v, input logic [31:0] t);
    bus.wb_valid[ch] = 1'b1;
    bus.wb_tag[ch*TAG_W +: TAG_W] = tag;
    bus.wb_val[ch*XLEN +: XLEN]   = v;
    bus.wb_tgt[ch*XLEN +: XLEN]   = t;
  endtask

  function automatic vec_t mk(input int av, ak, ard, w0v, w0t, w0d, w1v, w1t, w1d, qt,
                              input int e_cnt, e_ardy, e_atag, e_qr, e_qv, e_cm, e_ctag, e_we, e_rd, e_cval);
    vec_t v;
    v.av = av[0]; v.ak = ak[1:0]; v.ard = ard[4:0];
    v.w0v = w0v[0]; v.w0t = w0t[3:0]; v.w0d = w0d;
    v.w1v = w1v[0]; v.w1t = w1t[3:0]; v.w1d = w1d;
    v.qt = qt[3:0];
    v.e_cnt = e_cnt[4:0]; v.e_ardy = e_ardy[0]; v.e_atag = e_atag[3:0];
    v.e_qr = e_qr[0]; v.e_qv = e_qv;
    v.e_cm = e_cm[0]; v.e_ctag = e_ctag[3:0]; v.e_we = e_we[0]; v.e_rd = e_rd[4:0]; v.e_cval = e_cval;
    return v;
  endfunction

  initial begin
    //             av ak ard  w0v w0t w0d      w1v w1t w1d   qt  cnt rdy atag qr qv       cm ctag we rd cval
    vecs[0]  = mk(1, 0, 5,   0, 0, 0,        0, 0, 0,      0,  0, 1, 0,   0, 0,       0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,   1, 0, 'h1234,   0, 0, 0,      0,  1, 1, 1,   1, 'h1234,  0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      0,  1, 1, 1,   1, 'h1234,  0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      0,  0, 1, 1,   0, 0,       1, 0, 1, 5, 'h1234);
    vecs[4]  = mk(1, 0, 1,   0, 0, 0,        0, 0, 0,      0,  0, 1, 1,   0, 0,       0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 2,   0, 0, 0,        0, 0, 0,      1,  1, 1, 2,   0, 0,       0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 3,   1, 3, 'hdead,   0, 0, 0,      3,  2, 1, 3,   0, 0,       0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      3,  3, 1, 4,   0, 0,       0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,   0, 0, 0,        1, 3, 'h33,   3,  3, 1, 4,   1, 'h33,    0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0,   1, 1, 'h11,     0, 0, 0,      2,  3, 1, 4,   0, 0,       0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      1,  3, 1, 4,   1, 'h11,    0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0,   1, 2, 'h22,     0, 0, 0,      2,  2, 1, 4,   1, 'h22,    1, 1, 1, 1, 'h11);
    vecs[12] = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      3,  2, 1, 4,   1, 'h33,    0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      2,  1, 1, 4,   0, 0,       1, 2, 1, 2, 'h22);
    vecs[14] = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      0,  0, 1, 4,   0, 0,       1, 3, 1, 3, 'h33);
    vecs[15] = mk(1, 0, 0,   0, 0, 0,        0, 0, 0,      4,  0, 1, 4,   0, 0,       0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0,   1, 4, 7,        1, 4, 9,      4,  1, 1, 5,   1, 7,       0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      4,  1, 1, 5,   1, 7,       0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0,   0, 0, 0,        0, 0, 0,      4,  0, 1, 5,   0, 0,       1, 4, 0, 0, 7);

    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset count", bus.count, 0);
    check("reset alloc_ready", bus.alloc_ready, 1);
    check("reset alloc_tag", bus.alloc_tag, 0);
    check("reset cm_valid", bus.cm_valid, 0);
    check("reset flush", bus.flush, 0);

    // Table: basic commit, out-of-order writeback, ignored writeback, dual-channel collision.
    for (int i = 0; i < NV; i++) begin
      idle();
      if (vecs[i].av)  alloc(vecs[i].ak, vecs[i].ard, 1'b0, 32'h0);
      if (vecs[i].w0v) wb(0, vecs[i].w0t, vecs[i].w0d, 32'h0);
      if (vecs[i].w1v) wb(1, vecs[i].w1t, vecs[i].w1d, 32'h0);
      bus.q1_tag = vecs[i].qt;
      bus.q2_tag = vecs[i].qt;
      #1;
      check($sformatf("v%0d count", i), bus.count, vecs[i].e_cnt);
      check($sformatf("v%0d alloc_ready", i), bus.alloc_ready, vecs[i].e_ardy);
      check($sformatf("v%0d alloc_tag", i), bus.alloc_tag, vecs[i].e_atag);
      check($sformatf("v%0d q1_ready", i), bus.q1_ready, vecs[i].e_qr);
      check($sformatf("v%0d q2_ready", i), bus.q2_ready, vecs[i].e_qr);
      if (vecs[i].e_qr) begin
        check($sformatf("v%0d q1_val", i), bus.q1_val, vecs[i].e_qv);
        check($sformatf("v%0d q2_val", i), bus.q2_val, vecs[i].e_qv);
      end
      check($sformatf("v%0d cm_valid", i), bus.cm_valid, vecs[i].e_cm);
      check($sformatf("v%0d flush", i), bus.flush, 0);
      if (vecs[i].e_cm) begin
        check($sformatf("v%0d cm_tag", i), bus.cm_tag, vecs[i].e_ctag);
        check($sformatf("v%0d cm_we", i), bus.cm_we, vecs[i].e_we);
        check($sformatf("v%0d cm_rd", i), bus.cm_rd, vecs[i].e_rd);
        check($sformatf("v%0d cm_val", i), bus.cm_val, vecs[i].e_cval);
      end
      tick();
    end

    // Reset in the middle of operation discards live entries.
    idle(); alloc(K_REG, 5'd3, 1'b0, 32'h0); tick();
    tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("midrst count", bus.count, 0);
    check("midrst alloc_tag", bus.alloc_tag, 0);
    check("midrst alloc_ready", bus.alloc_ready, 1);

    // Fill all 16 entries, hold alloc while full, commit one, then tail wraps to 0.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); alloc(K_REG, 5'(i + 1), 1'b0, 32'h0); #1;
      check($sformatf("fill%0d alloc_tag", i), bus.alloc_tag, i);
      tick();
    end
    idle(); alloc(K_REG, 5'd31, 1'b0, 32'h0); wb(0, 4'd0, 32'hA0, 32'h0); #1;
    check("full count", bus.count, 16);
    check("full alloc_ready", bus.alloc_ready, 0);
    tick();
    idle(); alloc(K_REG, 5'd31, 1'b0, 32'h0); #1;
    check("full+commit count", bus.count, 16);
    tick();
    #1;
    check("wrap cm_valid", bus.cm_valid, 1);
    check("wrap cm_tag", bus.cm_tag, 0);
    check("wrap cm_val", bus.cm_val, 32'hA0);
    check("wrap count", bus.count, 15);
    check("wrap alloc_ready", bus.alloc_ready, 1);
    check("wrap alloc_tag", bus.alloc_tag, 0);
    tick();
    idle(); #1;
    check("refill count", bus.count, 16);
    check("refill alloc_ready", bus.alloc_ready, 0);
    rst = 1'b1; tick();
    rst = 1'b0;

    // Mispredicted branch flushes younger entries, including an already-ready one.
    idle(); alloc(K_BRANCH, 5'd0, 1'b1, 32'h100); tick();
    idle(); alloc(K_REG, 5'd7, 1'b0, 32'h0); wb(0, 4'd0, 32'h0, 32'h0); tick();
    idle(); alloc(K_REG, 5'd8, 1'b0, 32'h0); wb(1, 4'd1, 32'h5, 32'h0); tick();
    idle(); alloc(K_REG, 5'd9, 1'b0, 32'h0); #1;
    check("br cm_valid", bus.cm_valid, 1);
    check("br cm_tag", bus.cm_tag, 0);
    check("br cm_we", bus.cm_we, 0);
    check("br flush", bus.flush, 1);
    check("br flush_pc", bus.flush_pc, 32'h100);
    check("br count", bus.count, 2);
    check("br alloc_ready", bus.alloc_ready, 0);
    tick();
    idle(); bus.q1_tag = 4'd1; #1;
    check("postflush count", bus.count, 0);
    check("postflush flush", bus.flush, 0);
    check("postflush cm_valid", bus.cm_valid, 0);
    check("postflush alloc_ready", bus.alloc_ready, 1);
    check("postflush alloc_tag", bus.alloc_tag, 0);
    check("postflush q1_ready", bus.q1_ready, 0);
    alloc(K_BRANCH, 5'd0, 1'b0, 32'h300); tick();
    idle(); wb(0, 4'd0, 32'h0, 32'h0); tick();
    idle(); tick();
    #1;
    check("brok cm_valid", bus.cm_valid, 1);
    check("brok flush", bus.flush, 0);
    check("brok count", bus.count, 0);
    tick();

    // JALR with rdy held low for three cycles: state must freeze.
    idle(); alloc(K_JALR, 5'd1, 1'b0, 32'h0); tick();
    idle(); wb(1, 4'd1, 32'h44, 32'h200); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; alloc(K_REG, 5'd4, 1'b0, 32'h0); #1;
      check($sformatf("frz%0d count", i), bus.count, 1);
      check($sformatf("frz%0d cm_valid", i), bus.cm_valid, 0);
      check($sformatf("frz%0d flush", i), bus.flush, 0);
      tick();
    end
    idle(); rdy = 1'b1; #1;
    check("unfrz count", bus.count, 1);
    check("unfrz cm_valid", bus.cm_valid, 0);
    tick();
    #1;
    check("jalr cm_valid", bus.cm_valid, 1);
    check("jalr cm_tag", bus.cm_tag, 1);
    check("jalr cm_we", bus.cm_we, 1);
    check("jalr cm_rd", bus.cm_rd, 1);
    check("jalr cm_val", bus.cm_val, 32'h44);
    check("jalr flush", bus.flush, 1);
    check("jalr flush_pc", bus.flush_pc, 32'h200);
    tick();
    #1;
    check("jalr post count", bus.count, 0);
    check("jalr post flush", bus.flush, 0);

    // STORE is ready at alloc and commits without any writeback.
    alloc(K_STORE, 5'd9, 1'b0, 32'h0); tick();
    idle(); tick();
    #1;
    check("st cm_valid", bus.cm_valid, 1);
    check("st cm_store", bus.cm_store, 1);
    check("st cm_we", bus.cm_we, 0);
    check("st flush", bus.flush, 0);
    tick();
    #1;
    check("st post cm_store", bus.cm_store, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
